// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Define MDU_DIV_EN to build the DIV/DIVU datapath; otherwise divides complete immediately as no-ops.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic               neg_res;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MDU_DIV_EN
  logic               is_div;
  logic               neg_rem;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   rs_saved;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
`endif

  assign signed_op = ~op[0];
  assign a_abs = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign b_abs = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // acc holds {partial product, remaining multiplier bits} for multiply,
  // and {partial remainder, dividend/quotient bits} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_mag};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    acc_neg  = -acc;
    fix_hi   = neg_res ? acc_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_lo   = neg_res ? acc_neg[WIDTH-1:0] : acc[WIDTH-1:0];
`ifdef MDU_DIV_EN
    div_shift = {acc, 1'b0};
    div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, b_mag};
    div_next  = div_diff[WIDTH] ? div_shift[2*WIDTH-1:0]
                                : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    if (is_div) begin
      if (div_zero) begin
        fix_hi = rs_saved;
        fix_lo = '1;
      end else if (div_ovf) begin
        fix_hi = '0;
        fix_lo = MIN_NEG;
      end else begin
        fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      b_mag   <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      rs_saved <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef MDU_DIV_EN
            is_div   <= op[1];
            neg_rem  <= signed_op & rs_data[WIDTH-1];
            div_zero <= (rt_data == '0);
            div_ovf  <= signed_op && (rs_data == MIN_NEG) && (rt_data == '1);
            rs_saved <= rs_data;
`else
            if (op[1]) begin
              done <= 1'b1;
            end else
`endif
            begin
              state   <= ITER;
              busy    <= 1'b1;
              count   <= CW'(WIDTH - 1);
              b_mag   <= b_abs;
              acc     <= {{WIDTH{1'b0}}, a_abs};
              neg_res <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            end
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        ITER: begin
`ifdef MDU_DIV_EN
          acc <= is_div ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          count <= count - 1'b1;
          if (count == '0) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table, corner sequences and random ops vs. an arithmetic model.
// Expectations for divides follow whether MDU_DIV_EN is defined for the build.
module tb_mdu_iter;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  logic [31:0] mh = '0;
  logic [31:0] ml = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference results straight from MIPS arithmetic rules.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ph, input logic [31:0] pl,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    h = ph;
    l = pl;
    case (o)
      2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
      2'b10: if (DIV_EN) begin
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = 32'h80000000; end
        else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      end
      default: if (DIV_EN) begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Called just after a falling edge; returns at the falling edge of the done cycle.
  task automatic exec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic mvh, input logic mvl, output int bc);
    start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = mvh; mtlo = mvl;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    bc = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    total++;
    if (!done) begin
      bad++;
      $display("[TB] FAIL done_timeout: got done=%b, want 1 within 40 cycles", done);
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el);
    int bc;
    logic [31:0] xh, xl;
    bit nodiv;
    nodiv = o[1] && !DIV_EN;
    xh = nodiv ? mh : eh;
    xl = nodiv ? ml : el;
    exec(o, a, b, 1'b0, 1'b0, bc);
    check({name, "_hi"}, hi, xh);
    check({name, "_lo"}, lo, xl);
    check({name, "_busy_cycles"}, 32'(bc), nodiv ? 32'd0 : 32'd33);
    mh = xh;
    ml = xl;
  endtask

  initial begin
    int bc;
    logic [1:0]  ro;
    logic [31:0] ra, rb, eh, el;

    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
    vecs[3]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4]  = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
    vecs[10] = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[11] = '{2'b11, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // MTHI in IDLE: next edge, no done pulse
    rs_data = 32'hDEAD0000; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hDEAD0000);
    check("mthi_done", 32'(done), 32'h0);
    mh = 32'hDEAD0000;

    // Reset during ITER aborts everything immediately
    start = 1'b1; op = 2'b01; rs_data = 32'h12345678; rt_data = 32'h00009ABC;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mh = '0; ml = '0;
    @(negedge clk);
    run_check("post_rst_multu", 2'b01, 32'd3, 32'd5, 32'h0, 32'd15);

    // Single-cycle done pulse
    @(negedge clk);
    check("done_width", 32'(done), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // Vector table (ops issued back-to-back in each done cycle)
    foreach (vecs[i]) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // Moves and a stray start while busy are ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'h00001000; rt_data = 32'h00000010;
    @(negedge clk);
    rs_data = 32'h55555555; rt_data = 32'h3; mthi = 1'b1; mtlo = 1'b1; op = 2'b00;
    repeat (10) @(negedge clk);
    check("busy_mv_hi", hi, mh);
    check("busy_mv_lo", lo, ml);
    check("busy_mv_busy", 32'(busy), 32'h1);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    for (int n = 0; n < 40 && !done; n++) @(negedge clk);
    check("busy_mv_done", 32'(done), 32'h1);
    check("busy_mv_res_hi", hi, 32'h0);
    check("busy_mv_res_lo", lo, 32'h00010000);
    mh = 32'h0; ml = 32'h00010000;

    // start wins over same-cycle moves
    exec(2'b01, 32'd6, 32'd7, 1'b1, 1'b1, bc);
    check("start_mv_lo", lo, 32'd42);
    check("start_mv_hi", hi, 32'd0);
    mh = 32'd0; ml = 32'd42;

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      model(ro, ra, rb, mh, ml, eh, el);
      run_check($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, eh, el);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
